sprite_plotter: RTL and testbench

- Consumer end of the sprite-drawing interface.
- Accepts one draw request per sprite: base x/y, colour, and an erase flag.
- Rasterises a SPRITE_W x SPRITE_H box into a stream of single-pixel writes for the VGA adapter, one pixel per clock.
- Clips pixels that fall off-screen and signals completion back to the requesting datapath/FSM.

---
 rtl/sprite_plotter.sv | 187 ++++++++++++++++++
 tb/tb_sprite_plotter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// sprite_plotter: consumer end of the sprite-drawing interface.
// Captures one draw request (base x/y, colour, erase) and rasterises a
// SPRITE_W x SPRITE_H box as one pixel write per clock for the VGA adapter.
// Pixels whose column/row fall off-screen are issued with vga_plot low.
//
// Ports:
//   clk        system clock, rising edge
//   reset_N    asynchronous active-low reset
//   abort      synchronous cancel, returns to IDLE on the next edge
//   req        draw request (level, held until ack)
//   x_in/y_in  sprite top-left column/row
//   colour_in  sprite colour
//   erase      1 = draw colour 000 instead of colour_in
//   ack        one-cycle pulse: request captured
//   busy       high while not idle
//   done       one-cycle pulse after the last pixel cycle
//   vga_x/vga_y/vga_colour/vga_plot  registered pixel write
module sprite_plotter #(
   parameter int unsigned SPRITE_W = 10,
   parameter int unsigned SPRITE_H = 10,
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       reset_N,
   input  logic       abort,
   input  logic       req,
   input  logic [7:0] x_in,
   input  logic [6:0] y_in,
   input  logic [2:0] colour_in,
   input  logic       erase,
   output logic       ack,
   output logic       busy,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   localparam logic [4:0] ColLast = 5'(SPRITE_W - 1);
   localparam logic [4:0] RowLast = 5'(SPRITE_H - 1);
   localparam logic [8:0] ScrWLim = 9'(SCREEN_W);
   localparam logic [7:0] ScrHLim = 8'(SCREEN_H);

   typedef enum logic [1:0] {StIdle, StDraw, StFinish} state_e;

   state_e     state_q, state_d;
   logic [4:0] col_q, col_d, row_q, row_d;
   logic [7:0] xb_q, xb_d;
   logic [6:0] yb_q, yb_d;
   logic [2:0] colour_q, colour_d;
   // Set once the final pixel has been registered; the following DRAW edge
   // emits done instead of another pixel.
   logic       last_q, last_d;
   logic       ack_q, ack_d, busy_q, busy_d, done_q, done_d, plot_q, plot_d;
   logic [7:0] vx_q, vx_d;
   logic [6:0] vy_q, vy_d;
   logic [2:0] vc_q, vc_d;

   // Sums are one bit wider than the coordinates so a wrap past 255/127
   // is still seen as off-screen.
   logic [8:0] x_sum;
   logic [7:0] y_sum;
   logic       on_screen;

   assign x_sum     = {1'b0, xb_q} + {4'b0, col_q};
   assign y_sum     = {1'b0, yb_q} + {3'b0, row_q};
   assign on_screen = (x_sum < ScrWLim) && (y_sum < ScrHLim);

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      xb_d     = xb_q;
      yb_d     = yb_q;
      colour_d = colour_q;
      last_d   = last_q;
      ack_d    = 1'b0;
      done_d   = 1'b0;
      plot_d   = 1'b0;
      busy_d   = busy_q;
      vx_d     = vx_q;
      vy_d     = vy_q;
      vc_d     = vc_q;

      if (abort) begin
         state_d = StIdle;
         col_d   = '0;
         row_d   = '0;
         last_d  = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               busy_d = 1'b0;
               if (req) begin
                  xb_d     = x_in;
                  yb_d     = y_in;
                  colour_d = erase ? 3'b000 : colour_in;
                  col_d    = '0;
                  row_d    = '0;
                  last_d   = 1'b0;
                  ack_d    = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = StDraw;
               end
            end
            StDraw: begin
               busy_d = 1'b1;
               if (last_q) begin
                  done_d  = 1'b1;
                  last_d  = 1'b0;
                  state_d = StFinish;
               end else begin
                  vx_d   = x_sum[7:0];
                  vy_d   = y_sum[6:0];
                  vc_d   = colour_q;
                  plot_d = on_screen;
                  if (col_q == ColLast) begin
                     col_d = '0;
                     if (row_q == RowLast) begin
                        row_d  = '0;
                        last_d = 1'b1;
                     end else begin
                        row_d = row_q + 5'd1;
                     end
                  end else begin
                     col_d = col_q + 5'd1;
                  end
               end
            end
            StFinish: begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end
            default: begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state_q  <= StIdle;
         col_q    <= '0;
         row_q    <= '0;
         xb_q     <= '0;
         yb_q     <= '0;
         colour_q <= '0;
         last_q   <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         vx_q     <= '0;
         vy_q     <= '0;
         vc_q     <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         xb_q     <= xb_d;
         yb_q     <= yb_d;
         colour_q <= colour_d;
         last_q   <= last_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         plot_q   <= plot_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         vc_q     <= vc_d;
      end
   end

   assign ack        = ack_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign vga_x      = vx_q;
   assign vga_y      = vy_q;
   assign vga_colour = vc_q;
   assign vga_plot   = plot_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed testbench for sprite_plotter with the default 10x10 sprite on a
// 160x120 screen. Inputs change 1 ns after a rising edge; outputs are
// checked at the same point.
module tb_sprite_plotter;

   localparam int W = 10;
   localparam int H = 10;

   logic       clk = 1'b0;
   logic       reset_N, abort, req, erase;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] colour_in;
   logic       ack, busy, done, vga_plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   int checks = 0;
   int errors = 0;

   sprite_plotter dut (
      .clk        (clk),
      .reset_N    (reset_N),
      .abort      (abort),
      .req        (req),
      .x_in       (x_in),
      .y_in       (y_in),
      .colour_in  (colour_in),
      .erase      (erase),
      .ack        (ack),
      .busy       (busy),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise req with the given sprite and check the capture pulse.
   task automatic start_req(input int x, input int y, input logic [2:0] c, input logic e);
      x_in = 8'(x); y_in = 7'(y); colour_in = c; erase = e; req = 1'b1;
      step();
      checks++;
      if (ack !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_ack: ack=%b busy=%b required ack=1 busy=1", ack, busy);
      end
   endtask

   // Walk the W*H pixel cycles, the done cycle and the idle cycle after it.
   // With hold set, req stays high and the inputs switch to (nx,ny,nc)
   // mid-sprite; the current sprite must not change.
   task automatic draw_body(input int x, input int y, input logic [2:0] c, input logic e,
                            input bit hold, input int exp_cnt,
                            input int nx, input int ny, input logic [2:0] nc);
      int         cnt = 0;
      int         sx, sy;
      logic       ep;
      logic [2:0] ec;
      if (!hold) req = 1'b0;
      ec = e ? 3'b000 : c;
      for (int k = 0; k < W * H; k++) begin
         if (hold && k == 50) begin
            x_in = 8'(nx); y_in = 7'(ny); colour_in = nc; erase = 1'b0;
         end
         step();
         sx = x + (k % W);
         sy = y + (k / W);
         ep = (sx < 160) && (sy < 120);
         checks++;
         if (vga_plot !== ep || busy !== 1'b1 || done !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL pix%0d_ctrl: plot=%b busy=%b done=%b ack=%b required plot=%b busy=1 done=0 ack=0",
                     k, vga_plot, busy, done, ack, ep);
         end
         if (vga_plot === 1'b1) cnt++;
         if (ep) begin
            checks++;
            if (vga_x !== 8'(sx) || vga_y !== 7'(sy) || vga_colour !== ec) begin
               errors++;
               $display("FAIL pix%0d_data: x=%0d y=%0d colour=%b required x=%0d y=%0d colour=%b",
                        k, vga_x, vga_y, vga_colour, sx, sy, ec);
            end
         end
      end
      checks++;
      if (cnt != exp_cnt) begin
         errors++;
         $display("FAIL plot_count: got %0d required %0d", cnt, exp_cnt);
      end
      step();
      checks++;
      if (done !== 1'b1 || vga_plot !== 1'b0 || busy !== 1'b1 || ack !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle: done=%b plot=%b busy=%b ack=%b required 1 0 1 0",
                  done, vga_plot, busy, ack);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
         errors++;
         $display("FAIL idle_cycle: done=%b busy=%b ack=%b required 0 0 0", done, busy, ack);
      end
   endtask

   task automatic test_reset();
      reset_N = 1'b0; abort = 1'b0; req = 1'b0; erase = 1'b0;
      x_in = '0; y_in = '0; colour_in = '0;
      #3;
      checks++;
      if ({ack, busy, done, vga_plot, vga_x, vga_y, vga_colour} !== 22'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {ack, busy, done, vga_plot, vga_x, vga_y, vga_colour});
      end
      step();
      reset_N = 1'b1;
      step();
   endtask

   task automatic test_basic();
      start_req(20, 30, 3'b101, 1'b0);
      draw_body(20, 30, 3'b101, 1'b0, 1'b0, 100, 0, 0, 3'b000);
   endtask

   task automatic test_erase();
      start_req(20, 30, 3'b101, 1'b1);
      draw_body(20, 30, 3'b101, 1'b1, 1'b0, 100, 0, 0, 3'b000);
   endtask

   task automatic test_clip_edge();
      start_req(155, 115, 3'b011, 1'b0);
      draw_body(155, 115, 3'b011, 1'b0, 1'b0, 25, 0, 0, 3'b000);
   endtask

   task automatic test_clip_overflow();
      start_req(250, 0, 3'b110, 1'b0);
      draw_body(250, 0, 3'b110, 1'b0, 1'b0, 0, 0, 0, 3'b000);
   endtask

   task automatic test_back_to_back();
      start_req(5, 6, 3'b001, 1'b0);
      draw_body(5, 6, 3'b001, 1'b0, 1'b1, 100, 40, 50, 3'b111);
      step();
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_ack: ack=%b required 1", ack);
      end
      draw_body(40, 50, 3'b111, 1'b0, 1'b0, 100, 0, 0, 3'b000);
   endtask

   task automatic test_abort();
      start_req(10, 10, 3'b010, 1'b0);
      req = 1'b0;
      for (int k = 0; k < 38; k++) step();
      checks++;
      if (vga_plot !== 1'b1 || vga_x !== 8'd17 || vga_y !== 7'd13) begin
         errors++;
         $display("FAIL abort_pix37: plot=%b x=%0d y=%0d required 1 17 13", vga_plot, vga_x, vga_y);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || vga_plot !== 1'b0 || done !== 1'b0 || ack !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b plot=%b done=%b ack=%b required 0 0 0 0",
                  busy, vga_plot, done, ack);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b busy=%b required 0 0", done, busy);
         end
      end
      // abort wins over a simultaneous request
      req = 1'b1; abort = 1'b1;
      step();
      abort = 1'b0; req = 1'b0;
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_priority: ack=%b busy=%b required 0 0", ack, busy);
      end
      step();
      start_req(0, 0, 3'b100, 1'b0);
      draw_body(0, 0, 3'b100, 1'b0, 1'b0, 100, 0, 0, 3'b000);
   endtask

   task automatic test_reset_mid_draw();
      start_req(30, 40, 3'b111, 1'b0);
      req = 1'b0;
      for (int k = 0; k < 20; k++) step();
      #2;
      reset_N = 1'b0;
      #1;
      checks++;
      if ({ack, busy, done, vga_plot, vga_x, vga_y, vga_colour} !== 22'b0) begin
         errors++;
         $display("FAIL reset_mid_draw: got %h required 0",
                  {ack, busy, done, vga_plot, vga_x, vga_y, vga_colour});
      end
      step();
      reset_N = 1'b1;
      step();
      start_req(100, 60, 3'b001, 1'b0);
      draw_body(100, 60, 3'b001, 1'b0, 1'b0, 100, 0, 0, 3'b000);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_erase();
      test_clip_edge();
      test_clip_overflow();
      test_back_to_back();
      test_abort();
      test_reset_mid_draw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
